// File: rtl/sha_arb_pkg.sv
// Shared widths and FSM state type for the sha1 request arbiter.
package sha_arb_pkg;
  localparam int SHA1_ID_W     = 32;
  localparam int SHA1_LEN_W    = 61;
  localparam int SHA1_DIGEST_W = 160;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;
endpackage

// File: rtl/sha1_arbiter_if.sv
// Requester, core and tagged-result buses of sha1_arbiter.
// Valid/ready: a beat transfers on a rising clk edge where valid and ready are both high; results have no ready.
interface sha1_arbiter_if #(parameter int N = 4);
  import sha_arb_pkg::*;
  localparam int SRC_W = $clog2(N);

  logic [N-1:0]            s_tvalid;
  logic [N-1:0]            s_tready;
  logic [N-1:0]            s_tlast;
  logic [N*SHA1_ID_W-1:0]  s_tid;
  logic [N*8-1:0]          s_tdata;

  logic                    c_tvalid;
  logic                    c_tready;
  logic                    c_tlast;
  logic [SHA1_ID_W-1:0]    c_tid;
  logic [7:0]              c_tdata;

  logic                     c_ovalid;
  logic [SHA1_ID_W-1:0]     c_oid;
  logic [SHA1_LEN_W-1:0]    c_olen;
  logic [SHA1_DIGEST_W-1:0] c_osha;

  logic                     ovalid;
  logic [SRC_W-1:0]         osrc;
  logic [SHA1_ID_W-1:0]     oid;
  logic [SHA1_LEN_W-1:0]    olen;
  logic [SHA1_DIGEST_W-1:0] osha;
  logic                     err;

  modport slave (
    input  s_tvalid, s_tlast, s_tid, s_tdata, c_tready, c_ovalid, c_oid, c_olen, c_osha,
    output s_tready, c_tvalid, c_tlast, c_tid, c_tdata, ovalid, osrc, oid, olen, osha, err
  );

  modport master (
    output s_tvalid, s_tlast, s_tid, s_tdata, c_tready, c_ovalid, c_oid, c_olen, c_osha,
    input  s_tready, c_tvalid, c_tlast, c_tid, c_tdata, ovalid, osrc, oid, olen, osha, err
  );
endinterface

// File: rtl/sha_tag_fifo.sv
// Synchronous FIFO holding the requester index of each granted message until its digest returns.
module sha_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (do_pop) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/sha1_arbiter.sv
// Message-level round-robin sharing of one sha1 core between N byte-stream requesters,
// with each registered digest tagged by the requester that sent the message.
module sha1_arbiter
  import sha_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  sha1_arbiter_if.slave bus,
  output arb_state_t    state_o
);
  localparam int SRC_W = $clog2(N);

  // First requester after ptr, wrapping; the lowest scan distance wins.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [N-1:0] req, input logic [SRC_W-1:0] ptr);
    logic [SRC_W-1:0] pick;
    int idx;
    pick = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) pick = SRC_W'(idx);
    end
    return pick;
  endfunction

  arb_state_t       state_q, state_d;
  logic [SRC_W-1:0] gnt_q, gnt_d, rr_q, rr_d, pick;
  logic             push, pop, full, empty;
  logic [SRC_W-1:0] head;
  logic             tvalid, tlast;
  logic [SHA1_ID_W-1:0] tid;
  logic [7:0]       tdata;
  logic [N-1:0]     tready;

  logic                     ovalid_q, err_q;
  logic [SRC_W-1:0]         osrc_q;
  logic [SHA1_ID_W-1:0]     oid_q;
  logic [SHA1_LEN_W-1:0]    olen_q;
  logic [SHA1_DIGEST_W-1:0] osha_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    push    = 1'b0;
    pick    = rr_pick(bus.s_tvalid, rr_q);
    tvalid  = 1'b0;
    tlast   = 1'b0;
    tid     = '0;
    tdata   = '0;
    tready  = '0;
    case (state_q)
      IDLE: begin
        if ((|bus.s_tvalid) && !full) begin
          gnt_d   = pick;
          push    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        tvalid        = bus.s_tvalid[gnt_q];
        tlast         = bus.s_tlast[gnt_q];
        tid           = bus.s_tid[int'(gnt_q)*SHA1_ID_W +: SHA1_ID_W];
        tdata         = bus.s_tdata[int'(gnt_q)*8 +: 8];
        tready[gnt_q] = bus.c_tready;
        if (tvalid && bus.c_tready && tlast) begin
          rr_d    = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= SRC_W'(N-1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  // A result with no outstanding tag still pulses ovalid; it is flagged through err.
  assign pop = bus.c_ovalid & ~empty;

  sha_tag_fifo #(.W(SRC_W), .DEPTH(DEPTH)) u_tags (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (pick),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovalid_q <= 1'b0;
      osrc_q   <= '0;
      oid_q    <= '0;
      olen_q   <= '0;
      osha_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      ovalid_q <= bus.c_ovalid;
      if (bus.c_ovalid) begin
        osrc_q <= empty ? '0 : head;
        oid_q  <= bus.c_oid;
        olen_q <= bus.c_olen;
        osha_q <= bus.c_osha;
        if (empty) err_q <= 1'b1;
      end
    end
  end

  assign bus.c_tvalid = tvalid;
  assign bus.c_tlast  = tlast;
  assign bus.c_tid    = tid;
  assign bus.c_tdata  = tdata;
  assign bus.s_tready = tready;
  assign bus.ovalid   = ovalid_q;
  assign bus.osrc     = osrc_q;
  assign bus.oid      = oid_q;
  assign bus.olen     = olen_q;
  assign bus.osha     = osha_q;
  assign bus.err      = err_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_sha1_arbiter.sv
// Directed bench for sha1_arbiter: requester drivers, a sha1 core stand-in and a tagged-result scoreboard.
`timescale 1ns/1ps
module tb_sha1_arbiter;
  import sha_arb_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 2;
  localparam int SRC_W = $clog2(N);
  localparam int RES_W = SRC_W + SHA1_ID_W + SHA1_LEN_W + SHA1_DIGEST_W;
  localparam logic [159:0] ABC_SHA = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  arb_state_t state;

  sha1_arbiter_if #(.N(N)) bus ();

  sha1_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [RES_W-1:0] exp_q[$];
  logic [SRC_W-1:0] gnt_exp_q[$];

  bit          act[N];
  bit          acc[N];
  bit          gaps[N];
  bit          abc[N];
  int          len[N];
  int          pos[N];
  logic [31:0] mid[N];

  bit hold_res   = 1'b0;
  bit rand_ready = 1'b0;
  bit force_ov   = 1'b0;
  int core_delay = 3;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int src, input int k, input bit is_abc);
    if (is_abc) return 8'(8'h61 + k);
    return 8'((src << 6) ^ (k * 13));
  endfunction

  function automatic logic [159:0] sha_of(input logic [31:0] id, input logic [60:0] l);
    if (id == 32'd7 && l == 61'd3) return ABC_SHA;
    return {id, ~id, l[31:0], id ^ 32'hc3a5_5a3c, l[31:0] + id};
  endfunction

  function automatic logic [RES_W-1:0] pack_res(input int src, input logic [31:0] id, input int l,
                                                input logic [159:0] sha);
    return {SRC_W'(src), id, SHA1_LEN_W'(l), sha};
  endfunction

  function automatic bit any_act();
    bit a = 1'b0;
    for (int i = 0; i < N; i++) a |= act[i];
    return a;
  endfunction

  task automatic expect_msg(input int src, input logic [31:0] id, input int l, input logic [159:0] sha);
    gnt_exp_q.push_back(SRC_W'(src));
    exp_q.push_back(pack_res(src, id, l, sha));
  endtask

  task automatic start_msg(input int src, input int l, input logic [31:0] id, input bit g, input bit is_abc);
    len[src]  = l;
    mid[src]  = id;
    gaps[src] = g;
    abc[src]  = is_abc;
    pos[src]  = 0;
    act[src]  = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"},    state,        IDLE);
    chk({tag, "_s_tready"}, bus.s_tready, 4'b0000);
    chk({tag, "_c_tvalid"}, bus.c_tvalid, 1'b0);
    chk({tag, "_c_tlast"},  bus.c_tlast,  1'b0);
    chk({tag, "_c_tid"},    bus.c_tid,    32'd0);
    chk({tag, "_c_tdata"},  bus.c_tdata,  8'd0);
    chk({tag, "_ovalid"},   bus.ovalid,   1'b0);
    chk({tag, "_osrc"},     bus.osrc,     2'd0);
    chk({tag, "_oid"},      bus.oid,      32'd0);
    chk({tag, "_olen"},     bus.olen,     61'd0);
    chk({tag, "_osha"},     bus.osha,     160'd0);
    chk({tag, "_err"},      bus.err,      1'b0);
  endtask

  // Hold reset across two falling edges, dropping bench bookkeeping for abandoned work.
  task automatic do_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    gnt_exp_q.delete();
    #2 rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || gnt_exp_q.size() != 0 || any_act()) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", 32'(exp_q.size() + gnt_exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_state(input arb_state_t s, input int budget);
    int k = 0;
    while (state !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_state", state, s);
  endtask

  // Requester drivers: advance on an accepted beat, present the current byte.
  initial begin
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.s_tid    = '0;
    bus.s_tdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          acc[i] = 1'b0;
          if (pos[i] == len[i] - 1) act[i] = 1'b0;
          else pos[i]++;
        end
        if (rst) act[i] = 1'b0;
        bus.s_tvalid[i]       = act[i] && (!gaps[i] || $urandom_range(0, 2) != 0);
        bus.s_tlast[i]        = act[i] && (pos[i] == len[i] - 1);
        bus.s_tid[i*32 +: 32] = act[i] ? mid[i] : 32'd0;
        bus.s_tdata[i*8 +: 8] = act[i] ? byte_of(i, pos[i], abc[i]) : 8'd0;
      end
    end
  end

  // Core stand-in: counts bytes per message and returns a result core_delay cycles after tlast.
  initial begin
    logic [31:0] cq_id[$];
    logic [60:0] cq_len[$];
    int          cq_due[$];
    int          cyc;
    int          nbytes;
    cyc = 0;
    nbytes = 0;
    bus.c_tready = 1'b1;
    bus.c_ovalid = 1'b0;
    bus.c_oid    = '0;
    bus.c_olen   = '0;
    bus.c_osha   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nbytes = 0;
        cq_id.delete();
        cq_len.delete();
        cq_due.delete();
      end else if (bus.c_tvalid && bus.c_tready) begin
        nbytes++;
        if (bus.c_tlast) begin
          cq_id.push_back(bus.c_tid);
          cq_len.push_back(61'(nbytes));
          cq_due.push_back(cyc + core_delay);
          nbytes = 0;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      bus.c_ovalid = 1'b0;
      if (force_ov) begin
        force_ov     = 1'b0;
        bus.c_ovalid = 1'b1;
        bus.c_oid    = 32'hbad0_0001;
        bus.c_olen   = 61'd9;
        bus.c_osha   = sha_of(32'hbad0_0001, 61'd9);
      end else if (!rst && !hold_res && cq_id.size() != 0 && cyc >= cq_due[0]) begin
        bus.c_ovalid = 1'b1;
        bus.c_oid    = cq_id.pop_front();
        bus.c_olen   = cq_len.pop_front();
        bus.c_osha   = sha_of(bus.c_oid, bus.c_olen);
        void'(cq_due.pop_front());
      end
      bus.c_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: core-side stream integrity, result latency and the tagged-result scoreboard.
  initial begin
    bit               in_msg;
    bit               ov_prev;
    int               mpos;
    logic [SRC_W-1:0] cur;
    in_msg  = 1'b0;
    ov_prev = 1'b0;
    mpos    = 0;
    cur     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_msg  = 1'b0;
        ov_prev = 1'b0;
        for (int i = 0; i < N; i++) acc[i] = 1'b0;
        continue;
      end
      chk("ovalid_latency", bus.ovalid, ov_prev);
      ov_prev = bus.c_ovalid;
      if (bus.ovalid) begin
        chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("result", {bus.osrc, bus.oid, bus.olen, bus.osha}, exp_q.pop_front());
      end
      for (int i = 0; i < N; i++) if (bus.s_tvalid[i] && bus.s_tready[i]) acc[i] = 1'b1;
      if (bus.c_tvalid && bus.c_tready) begin
        if (!in_msg) begin
          chk("grant_expected", 32'(gnt_exp_q.size() != 0), 32'd1);
          cur    = (gnt_exp_q.size() != 0) ? gnt_exp_q.pop_front() : '0;
          in_msg = 1'b1;
          mpos   = 0;
        end
        chk("s_tready_owner", bus.s_tready, N'(1) << cur);
        chk("c_tid", bus.c_tid, mid[cur]);
        chk("c_tdata", bus.c_tdata, byte_of(cur, mpos, abc[cur]));
        mpos++;
        chk("c_tlast", bus.c_tlast, 1'(mpos == len[cur]));
        if (bus.c_tlast) in_msg = 1'b0;
      end
    end
  end

  initial begin
    #300_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0; acc[i] = 1'b0; gaps[i] = 1'b0; abc[i] = 1'b0;
      len[i] = 1; pos[i] = 0; mid[i] = '0;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    #2 rst = 1'b0;

    // Single requester 2 sends "abc" with id 7.
    @(negedge clk);
    expect_msg(2, 32'd7, 3, ABC_SHA);
    start_msg(2, 3, 32'd7, 1'b0, 1'b1);
    @(negedge clk);
    chk("pre_grant_state", state, IDLE);
    chk("pre_grant_c_tvalid", bus.c_tvalid, 1'b0);
    @(negedge clk);
    chk("grant_latency_state", state, BUSY);
    chk("grant_latency_c_tvalid", bus.c_tvalid, 1'b1);
    chk("grant_latency_s_tready", bus.s_tready, 4'b0100);
    wait_drain(200);

    // All four from reset: grant order 0,1,2,3.
    do_reset();
    @(negedge clk);
    rand_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      expect_msg(i, 32'(100 + i), 3 + 2*i, sha_of(32'(100 + i), 61'(3 + 2*i)));
      start_msg(i, 3 + 2*i, 32'(100 + i), 1'b0, 1'b0);
    end
    wait_drain(600);

    // Requester 1 long message with gaps while 0 and 3 wait: order 1,3,0.
    expect_msg(1, 32'd200, 200, sha_of(32'd200, 61'd200));
    start_msg(1, 200, 32'd200, 1'b1, 1'b0);
    wait_state(BUSY, 30);
    expect_msg(3, 32'd300, 4, sha_of(32'd300, 61'd4));
    expect_msg(0, 32'd301, 5, sha_of(32'd301, 61'd5));
    start_msg(3, 4, 32'd300, 1'b0, 1'b0);
    start_msg(0, 5, 32'd301, 1'b0, 1'b0);
    wait_drain(2000);

    // Results held: third grant waits on a full tag FIFO.
    rand_ready = 1'b0;
    hold_res   = 1'b1;
    expect_msg(1, 32'd400, 2, sha_of(32'd400, 61'd2));
    expect_msg(2, 32'd401, 2, sha_of(32'd401, 61'd2));
    expect_msg(0, 32'd402, 2, sha_of(32'd402, 61'd2));
    start_msg(1, 2, 32'd400, 1'b0, 1'b0);
    start_msg(2, 2, 32'd401, 1'b0, 1'b0);
    start_msg(0, 2, 32'd402, 1'b0, 1'b0);
    k = 0;
    while ((act[1] || act[2]) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("two_grants_done", 32'(act[1] || act[2]), 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("full_hold_state", state, IDLE);
      chk("full_hold_s_tready", bus.s_tready, 4'b0000);
    end
    hold_res = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.c_ovalid && k < 20);
    chk("release_c_ovalid", bus.c_ovalid, 1'b1);
    chk("release_state", state, IDLE);
    @(negedge clk);
    chk("after_pop_state", state, IDLE);
    @(negedge clk);
    chk("grant_after_pop_state", state, BUSY);
    chk("grant_after_pop_s_tready", bus.s_tready, 4'b0001);
    wait_drain(300);

    // Reset mid-message: outputs clear at once, FIFO is flushed, requester 0 wins afterwards.
    gnt_exp_q.push_back(SRC_W'(2));
    start_msg(2, 40, 32'd500, 1'b0, 1'b0);
    wait_state(BUSY, 20);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset("async_reset");
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    gnt_exp_q.delete();
    #2 rst = 1'b0;
    @(negedge clk);
    expect_msg(0, 32'd600, 3, sha_of(32'd600, 61'd3));
    expect_msg(3, 32'd601, 4, sha_of(32'd601, 61'd4));
    start_msg(3, 4, 32'd601, 1'b0, 1'b0);
    start_msg(0, 3, 32'd600, 1'b0, 1'b0);
    wait_drain(300);

    // Core result with no outstanding tag: osrc 0 and sticky err.
    chk("err_before", bus.err, 1'b0);
    exp_q.push_back(pack_res(0, 32'hbad0_0001, 9, sha_of(32'hbad0_0001, 61'd9)));
    force_ov = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("err_set", bus.err, 1'b1);
    repeat (5) @(negedge clk);
    chk("err_sticky", bus.err, 1'b1);
    chk("err_result_drained", 32'(exp_q.size()), 32'd0);
    do_reset();
    @(negedge clk);
    chk("err_cleared", bus.err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
